icache_fill_ctl: RTL and testbench

ICACHE_FILL_CTL -- requirements
Module: icache_fill_ctl

---
 rtl/icache_fill_ctl_pkg.sv | 53 +++++
 rtl/icache_fill_ctl_if.sv | 22 ++
 rtl/icache_fill_rr_arb.sv | 23 ++
 rtl/icache_fill_ctl.sv | 156 +++++++++++++++
 tb/tb_icache_fill_ctl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fill_ctl_pkg.sv
// Shared definitions for the icache fill controller: FSM state encoding,
// thread count, beats per fill, watchdog default and small helpers.
// Optional feature macro: ICACHE_FILL_TIMEOUT_EN (fill-return watchdog).
package icache_fill_ctl_pkg;

  localparam int unsigned NUM_THR_DFLT   = 4;
  localparam int unsigned BEATS_PER_FILL = 2;
  localparam int unsigned TO_CYC_DFLT    = 255;

  typedef logic [1:0] thr_id_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RTN  = 2'd2,
    S_DONE = 2'd3
  } fill_state_e;

  // Lowest-index invalid way wins; with a full set the victim pointer is used.
  function automatic logic [3:0] pick_victim(input logic [3:0] valid,
                                             input logic [3:0] vp);
    logic [3:0] res;
    logic       found;
    res   = vp;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!valid[i] && !found) begin
        res    = '0;
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic thr_id_t onehot_to_id(input logic [3:0] oh);
    thr_id_t id;
    id = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) id = thr_id_t'(i);
    end
    return id;
  endfunction

  function automatic logic [3:0] id_to_onehot(input thr_id_t id);
    return 4'b0001 << id;
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/icache_fill_ctl_if.sv
// L2 fill request/return bus between the icache fill controller (master)
// and the L2 side (slave).
interface icache_fill_ctl_if;
  import icache_fill_ctl_pkg::*;

  logic    l2_req_vld;
  logic    l2_req_rdy;
  thr_id_t l2_req_thr;
  logic    l2_rtn_vld;
  logic    l2_rtn_err;

  modport master (
    output l2_req_vld, l2_req_thr,
    input  l2_req_rdy, l2_rtn_vld, l2_rtn_err
  );

  modport slave (
    input  l2_req_vld, l2_req_thr,
    output l2_req_rdy, l2_rtn_vld, l2_rtn_err
  );

endinterface

// File: rtl/icache_fill_rr_arb.sv
// Four-requester round-robin arbiter: the search starts at ptr+1 (mod 4)
// and the first set request wins; gnt is one-hot or zero.
module icache_fill_rr_arb
  import icache_fill_ctl_pkg::*;
(
  input  logic [3:0] req,
  input  thr_id_t    ptr,
  output logic [3:0] gnt
);

  thr_id_t idx;

  // Rotating priority search; i == 4 wraps back to ptr itself.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = ptr + thr_id_t'(i);
      if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/icache_fill_ctl.sv
// Icache miss fill controller: arbitrates per-thread miss requests, issues
// one L2 fill at a time, writes two return beats into the victim way and
// signals completion to the requesting thread.
// Optional feature macro: ICACHE_FILL_TIMEOUT_EN adds a watchdog that forces
// an errored completion after TO_CYC cycles without a return beat.
module icache_fill_ctl
  import icache_fill_ctl_pkg::*;
#(
  parameter int unsigned NUM_THR = NUM_THR_DFLT,
  parameter int unsigned TO_CYC  = TO_CYC_DFLT
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [NUM_THR-1:0] miss_req,
  input  logic [3:0]         valid_way_s1,
  output logic [NUM_THR-1:0] miss_ack,
  icache_fill_ctl_if.master  l2,
  output logic               fill_wen,
  output logic [3:0]         fill_way,
  output logic               fill_beat,
  output logic [NUM_THR-1:0] fill_done,
  output logic               fill_err,
  output logic               busy
);

  localparam logic LAST_BEAT = 1'(BEATS_PER_FILL - 1);

  if ((NUM_THR != 4) || (TO_CYC == 0) || (TO_CYC > 255)) begin : g_bad_cfg
    $error("icache_fill_ctl: NUM_THR must be 4 and TO_CYC must be 1..255");
  end

  fill_state_e state;
  thr_id_t     rr_ptr;
  thr_id_t     thr;
  logic [3:0]  victim;
  logic [3:0]  vp;
  logic        vp_used;
  logic        beat;
  logic        err;
  logic [3:0]  gnt;
  logic        to_hit;

  icache_fill_rr_arb u_arb (
    .req (miss_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // The grant pulse must land in the IDLE cycle it is decided in, so it is
  // decoded from state rather than registered; rst_l keeps it low in reset.
  always_comb begin
    miss_ack = '0;
    if ((state == S_IDLE) && rst_l) miss_ack = gnt;
  end

`ifdef ICACHE_FILL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
  logic [7:0] timer;

  // Fires on the TO_CYC-th consecutive RTN cycle without a return beat.
  always_comb begin
    to_hit = (state == S_RTN) && !l2.l2_rtn_vld && (timer == TO_LAST);
  end

  // Watchdog counts idle RTN cycles; any beat or other state clears it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timer <= '0;
    end else if ((state == S_RTN) && !l2.l2_rtn_vld) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= '0;
    end
  end
`else
  // Without the watchdog RTN waits for its beats indefinitely.
  always_comb begin
    to_hit = 1'b0;
  end
`endif

  // Fill FSM with registered bus, write and completion outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= S_IDLE;
      rr_ptr        <= 2'd3;
      vp            <= 4'b0001;
      thr           <= '0;
      victim        <= '0;
      vp_used       <= 1'b0;
      beat          <= 1'b0;
      err           <= 1'b0;
      l2.l2_req_vld <= 1'b0;
      l2.l2_req_thr <= '0;
      fill_wen      <= 1'b0;
      fill_way      <= '0;
      fill_beat     <= 1'b0;
      fill_done     <= '0;
      fill_err      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      fill_wen  <= 1'b0;
      fill_done <= '0;
      fill_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt != '0) begin
            thr           <= onehot_to_id(gnt);
            victim        <= pick_victim(valid_way_s1, vp);
            vp_used       <= &valid_way_s1;
            beat          <= 1'b0;
            err           <= 1'b0;
            l2.l2_req_vld <= 1'b1;
            l2.l2_req_thr <= onehot_to_id(gnt);
            busy          <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (l2.l2_req_rdy) begin
            l2.l2_req_vld <= 1'b0;
            state         <= S_RTN;
          end
        end
        S_RTN: begin
          // Write strobe trails its return beat by one cycle.
          if (l2.l2_rtn_vld) begin
            fill_wen  <= !l2.l2_rtn_err;
            fill_way  <= victim;
            fill_beat <= beat;
            err       <= err | l2.l2_rtn_err;
            beat      <= 1'b1;
            if (beat == LAST_BEAT) begin
              fill_done <= id_to_onehot(thr);
              fill_err  <= err | l2.l2_rtn_err;
              state     <= S_DONE;
            end
          end else if (to_hit) begin
            err       <= 1'b1;
            fill_done <= id_to_onehot(thr);
            fill_err  <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr <= thr;
          if (vp_used) vp <= rotl4(vp);
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_ctl.sv
// Self-checking bench for icache_fill_ctl: a vector table of complete fills
// plus hand sequences for idle returns, reset mid-fill and the watchdog.
module tb_icache_fill_ctl;
  import icache_fill_ctl_pkg::*;

  localparam int unsigned TB_TO = 20;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  valid;
    int unsigned rdy_wait;
    logic        err0;
    logic        err1;
    thr_id_t     thr;
    logic [3:0]  way;
    logic        exp_err;
    logic [1:0]  wen;
  } vec_t;

  typedef struct {
    thr_id_t    thr;
    logic [3:0] way;
    logic       err;
    logic [1:0] wen;
  } exp_t;

  logic       clk;
  logic       rst_l;
  logic [3:0] miss_req;
  logic [3:0] valid_way_s1;
  logic [3:0] miss_ack;
  logic       fill_wen;
  logic [3:0] fill_way;
  logic       fill_beat;
  logic [3:0] fill_done;
  logic       fill_err;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [1:0]  wen_seen = '0;
  vec_t        vecs[11];

  icache_fill_ctl_if l2_bus();

  icache_fill_ctl #(.NUM_THR(4), .TO_CYC(TB_TO)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .miss_req     (miss_req),
    .valid_way_s1 (valid_way_s1),
    .miss_ack     (miss_ack),
    .l2           (l2_bus),
    .fill_wen     (fill_wen),
    .fill_way     (fill_way),
    .fill_beat    (fill_beat),
    .fill_done    (fill_done),
    .fill_err     (fill_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: checks write strobes and completions against the queue.
  always @(negedge clk) begin
    if (!rst_l) begin
      wen_seen = '0;
    end else begin
      if (miss_ack != '0) chk("ack_only_idle", 32'(busy), 32'd0);
      if (fill_wen) begin
        chk("wen_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("fill_way", 32'(fill_way), 32'(exp_q[0].way));
          wen_seen[fill_beat] = 1'b1;
        end
      end
      if (fill_done != '0) begin
        chk("done_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("fill_done", 32'(fill_done), 32'(4'b0001 << mon_e.thr));
          chk("fill_err", 32'(fill_err), 32'(mon_e.err));
          chk("wen_beats", 32'(wen_seen), 32'(mon_e.wen));
          wen_seen = '0;
        end
      end
    end
  end

  // Bounded wait for a grant pulse; returns at the negedge that shows it.
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      if (miss_ack != '0) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // One complete fill: grant, optional rdy stall, two return beats, done.
  task automatic run_vec(input vec_t v);
    bit got;
    miss_req     = v.req;
    valid_way_s1 = v.valid;
    wait_ack(got);
    if (!got) return;
    chk("miss_ack", 32'(miss_ack), 32'(4'b0001 << v.thr));
    exp_q.push_back('{thr: v.thr, way: v.way, err: v.exp_err, wen: v.wen});
    @(posedge clk); #1;
    l2_bus.l2_req_rdy = 1'b0;
    for (int unsigned k = 0; k < v.rdy_wait; k++) begin
      @(negedge clk);
      chk("req_vld_stall", 32'(l2_bus.l2_req_vld), 32'd1);
      chk("req_thr_stall", 32'(l2_bus.l2_req_thr), 32'(v.thr));
      @(posedge clk); #1;
    end
    l2_bus.l2_req_rdy = 1'b1;
    @(negedge clk);
    chk("req_vld", 32'(l2_bus.l2_req_vld), 32'd1);
    chk("req_thr", 32'(l2_bus.l2_req_thr), 32'(v.thr));
    @(posedge clk); #1;
    l2_bus.l2_req_rdy = 1'b0;
    @(negedge clk);
    chk("req_vld_drop", 32'(l2_bus.l2_req_vld), 32'd0);
    l2_bus.l2_rtn_vld = 1'b1;
    l2_bus.l2_rtn_err = v.err0;
    @(posedge clk); #1;
    l2_bus.l2_rtn_err = v.err1;
    @(posedge clk); #1;
    l2_bus.l2_rtn_vld = 1'b0;
    l2_bus.l2_rtn_err = 1'b0;
    @(negedge clk);
    chk("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int unsigned n;
    bit seen;

    //            req      valid    wait err0  err1  thr  way      err   wen
    vecs[0]  = '{4'b1111, 4'b0000, 0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 2'b11};
    vecs[1]  = '{4'b1111, 4'b0001, 0, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 2'b11};
    vecs[2]  = '{4'b1111, 4'b1011, 0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'b11};
    vecs[3]  = '{4'b1111, 4'b1111, 0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0, 2'b11};
    vecs[4]  = '{4'b1111, 4'b1111, 0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 2'b11};
    vecs[5]  = '{4'b1111, 4'b1111, 0, 1'b0, 1'b0, 2'd1, 4'b0100, 1'b0, 2'b11};
    vecs[6]  = '{4'b0100, 4'b0111, 5, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0, 2'b11};
    vecs[7]  = '{4'b0101, 4'b1111, 0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'b10};
    vecs[8]  = '{4'b1010, 4'b1110, 0, 1'b0, 1'b1, 2'd1, 4'b0001, 1'b1, 2'b01};
    vecs[9]  = '{4'b1001, 4'b1111, 0, 1'b1, 1'b1, 2'd3, 4'b0001, 1'b1, 2'b00};
    vecs[10] = '{4'b0001, 4'b1111, 0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 2'b11};

    rst_l             = 1'b0;
    miss_req          = 4'b1111;
    valid_way_s1      = 4'b0000;
    l2_bus.l2_req_rdy = 1'b0;
    l2_bus.l2_rtn_vld = 1'b0;
    l2_bus.l2_rtn_err = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(miss_ack), 32'd0);
    chk("rst_req_vld", 32'(l2_bus.l2_req_vld), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_wen", 32'(fill_wen), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    miss_req = 4'b0000;
    chk("table_drained", 32'(exp_q.size()), 32'd0);

    // Returns outside RTN must not write or start anything.
    l2_bus.l2_rtn_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rtn_wen", 32'(fill_wen), 32'd0);
      chk("idle_rtn_busy", 32'(busy), 32'd0);
    end
    l2_bus.l2_rtn_vld = 1'b0;
    @(posedge clk); #1;

    // Reset after the first beat abandons the fill without a completion.
    miss_req = 4'b0010;
    valid_way_s1 = 4'b0000;
    wait_ack(got);
    if (got) begin
      chk("rst_fill_ack", 32'(miss_ack), 32'(4'b0010));
      exp_q.push_back('{thr: 2'd1, way: 4'b0001, err: 1'b0, wen: 2'b11});
      @(posedge clk); #1;
      l2_bus.l2_req_rdy = 1'b1;
      @(posedge clk); #1;
      l2_bus.l2_req_rdy = 1'b0;
      miss_req = 4'b0000;
      l2_bus.l2_rtn_vld = 1'b1;
      @(posedge clk); #1;
      l2_bus.l2_rtn_vld = 1'b0;
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_wen", 32'(fill_wen), 32'd0);
      chk("midrst_done", 32'(fill_done), 32'd0);
      exp_q.delete();
      miss_req = 4'b1111;
      repeat (2) @(posedge clk);
      #1 rst_l = 1'b1;
    end
    run_vec('{4'b1111, 4'b0000, 0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 2'b11});
    miss_req = 4'b0000;

    // No return beat after acceptance.
    miss_req = 4'b0100;
    valid_way_s1 = 4'b0000;
    wait_ack(got);
    if (got) begin
      chk("to_ack", 32'(miss_ack), 32'(4'b0100));
`ifdef ICACHE_FILL_TIMEOUT_EN
      exp_q.push_back('{thr: 2'd2, way: 4'b0001, err: 1'b1, wen: 2'b00});
`else
      exp_q.push_back('{thr: 2'd2, way: 4'b0001, err: 1'b0, wen: 2'b11});
`endif
      @(posedge clk); #1;
      miss_req = 4'b0000;
      l2_bus.l2_req_rdy = 1'b1;
      @(posedge clk); #1;
      l2_bus.l2_req_rdy = 1'b0;
      seen = 1'b0;
      n = 0;
`ifdef ICACHE_FILL_TIMEOUT_EN
      while (!seen && n < TB_TO + 8) begin
        n++;
        @(negedge clk);
        if (fill_done != '0) seen = 1'b1;
      end
      chk("to_fired", 32'(seen), 32'd1);
      chk("to_latency", 32'(n >= TB_TO && n <= TB_TO + 2), 32'd1);
      @(posedge clk); #1;
`else
      while (n < 40) begin
        n++;
        @(negedge clk);
        if (fill_done != '0) seen = 1'b1;
      end
      chk("rtn_waits_done", 32'(seen), 32'd0);
      chk("rtn_waits_busy", 32'(busy), 32'd1);
      l2_bus.l2_rtn_vld = 1'b1;
      repeat (2) @(posedge clk);
      #1 l2_bus.l2_rtn_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
`endif
    end
    @(negedge clk);
    chk("end_idle", 32'(busy), 32'd0);
    chk("end_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
